debug_packet_tx: RTL and testbench

//  Debug-unit response framer between the MIPS pipeline debug logic and the UART transmitter.

---
 rtl/debug_packet_tx.sv | 186 ++++++++++++++++++
 tb/tb_debug_packet_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_packet_tx.sv
// Debug response framer: frames a data word plus info tag into LSB-first UART bytes.
// Optional PKT_CHECKSUM_EN appends an XOR checksum byte after the payload.
module debug_packet_tx #(
  parameter int BUS_SIZE   = 32,
  parameter int DATA_BITS  = 8,
  parameter int INFO_BYTES = 3
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_valid,
  input  logic [BUS_SIZE-1:0]             i_data,
  input  logic [INFO_BYTES*DATA_BITS-1:0] i_info,
  output logic                            o_ready,
  output logic                            o_tx_start,
  output logic [DATA_BITS-1:0]            o_tx_data,
  input  logic                            i_tx_done,
  output logic                            o_busy,
  output logic [15:0]                     o_pkt_count
);

  localparam int INFO_W    = INFO_BYTES * DATA_BITS;
  localparam int PKT_W     = BUS_SIZE + INFO_W;
  localparam int NUM_BYTES = PKT_W / DATA_BITS;
`ifdef PKT_CHECKSUM_EN
  localparam int LAST_IDX  = NUM_BYTES;
`else
  localparam int LAST_IDX  = NUM_BYTES - 1;
`endif
  localparam int IDX_W     = $clog2(NUM_BYTES + 1);

  localparam logic [IDX_W-1:0] PAYLOAD_LAST = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] FINAL_IDX    = IDX_W'(LAST_IDX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
`ifdef PKT_CHECKSUM_EN
    WAIT  = 2'd2,
    CSUM  = 2'd3
`else
    WAIT  = 2'd2
`endif
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic                 pending_vld_p0;
  logic [PKT_W-1:0]     pending_pkt_p0;
  logic [PKT_W-1:0]     active_pkt_p1;
  logic [IDX_W-1:0]     byte_idx;
  logic [DATA_BITS-1:0] tx_byte;
  logic [15:0]          pkt_count;

  logic                 accept;
  logic                 drain;
  logic                 advance;
  logic                 finish;
  logic                 tx_start;
`ifdef PKT_CHECKSUM_EN
  logic                 enter_csum;
  logic [DATA_BITS-1:0] csum;
`endif

  // Accept and drain are mutually exclusive: accept needs the slot empty, drain needs it full.
  assign accept = i_valid && !pending_vld_p0;

  always_comb begin
    state_d    = state_q;
    tx_start   = 1'b0;
    drain      = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
`ifdef PKT_CHECKSUM_EN
    enter_csum = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pending_vld_p0) begin
          drain   = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (i_tx_done) begin
          if (byte_idx == FINAL_IDX) begin
            finish  = 1'b1;
            state_d = IDLE;
          end
`ifdef PKT_CHECKSUM_EN
          else if (byte_idx == PAYLOAD_LAST) begin
            enter_csum = 1'b1;
            state_d    = CSUM;
          end
`endif
          else begin
            advance = 1'b1;
            state_d = START;
          end
        end
      end
`ifdef PKT_CHECKSUM_EN
      CSUM: begin
        tx_start = 1'b1;
        state_d  = WAIT;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control stage: pending flag, byte index, held output byte and packet counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pending_vld_p0 <= 1'b0;
      byte_idx       <= '0;
      tx_byte        <= '0;
      pkt_count      <= '0;
    end else begin
      if (accept) begin
        pending_vld_p0 <= 1'b1;
      end else if (drain) begin
        pending_vld_p0 <= 1'b0;
      end

      if (drain) begin
        byte_idx <= '0;
        tx_byte  <= pending_pkt_p0[DATA_BITS-1:0];
      end else if (advance) begin
        byte_idx <= byte_idx + IDX_W'(1);
        tx_byte  <= active_pkt_p1[2*DATA_BITS-1:DATA_BITS];
      end
`ifdef PKT_CHECKSUM_EN
      else if (enter_csum) begin
        byte_idx <= FINAL_IDX;
        tx_byte  <= csum ^ tx_byte;
      end
`endif

      if (finish) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

  // Data stage: captured packet and the shift register that feeds the next byte.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      pending_pkt_p0 <= {i_info, i_data};
    end
    if (drain) begin
      active_pkt_p1 <= pending_pkt_p0;
    end else if (advance) begin
      active_pkt_p1 <= active_pkt_p1 >> DATA_BITS;
    end
  end

`ifdef PKT_CHECKSUM_EN
  always_ff @(posedge i_clk) begin
    if (drain) begin
      csum <= '0;
    end else if ((state_q == WAIT) && i_tx_done) begin
      csum <= csum ^ tx_byte;
    end
  end
`endif

  assign o_ready     = !pending_vld_p0;
  assign o_tx_start  = tx_start;
  assign o_tx_data   = tx_byte;
  assign o_busy      = pending_vld_p0 || (state_q != IDLE);
  assign o_pkt_count = pkt_count;

endmodule

// File: tb/tb_debug_packet_tx.sv
// Scoreboard bench for debug_packet_tx: randomized packets, UART done model, reset abort.
module tb_debug_packet_tx;

`ifdef PKT_CHECKSUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif

  logic        clk;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_data;
  logic [23:0] i_info;
  logic        o_ready;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_done;
  logic        o_busy;
  logic [15:0] o_pkt_count;

  debug_packet_tx #(.BUS_SIZE(32), .DATA_BITS(8), .INFO_BYTES(3)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
    .i_info(i_info), .o_ready(o_ready), .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data), .i_tx_done(i_tx_done), .o_busy(o_busy),
    .o_pkt_count(o_pkt_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_pkts = 0;
  int mon_starts = 0;
  logic [7:0] exp_q[$];

  int dly_lo = 20, dly_hi = 20;
  int spn_req = 0, spn_ack = 0;
  int sos_req = 0, sos_ack = 0;
  int flush_req = 0, flush_ack = 0;
  int lat_req = 0, lat_ack = 0, lat_exp = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (bound expired)", name);
  endtask

  // Reference: byte k is bits [8k+7:8k] of the 56-bit {info,data} word; optional XOR byte last.
  function automatic void push_pkt(input logic [31:0] d, input logic [23:0] inf);
    logic [55:0] w;
    logic [7:0]  b;
    logic [7:0]  cs;
    w  = {inf, d};
    cs = 8'h00;
    for (int k = 0; k < 7; k++) begin
      b  = 8'((w >> (8 * k)) & 56'hFF);
      cs = cs ^ b;
      exp_q.push_back(b);
    end
`ifdef PKT_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    exp_pkts++;
  endfunction

  // UART model: done pulses a programmable number of cycles after each start.
  initial begin
    int cnt;
    cnt = 0;
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      i_tx_done = 1'b0;
      if (flush_req != flush_ack) begin
        cnt = 0;
        flush_ack = flush_req;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) i_tx_done = 1'b1;
      end
      if (o_tx_start && i_reset) begin
        cnt = int'($urandom_range(dly_hi, dly_lo));
        if (sos_req != sos_ack) begin
          i_tx_done = 1'b1;
          sos_ack = sos_req;
        end
      end
      if (spn_req != spn_ack) begin
        i_tx_done = 1'b1;
        spn_ack = spn_req;
      end
    end
  end

  // Monitor: pops the scoreboard on every start pulse, checks start timing.
  initial begin
    int pos;
    bit b2b_arm;
    int b2b_exp;
    logic [7:0] e;
    pos = 0;
    b2b_arm = 1'b0;
    b2b_exp = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!i_reset) begin
        pos = 0;
        b2b_arm = 1'b0;
      end else begin
        if (o_tx_start) begin
          mon_starts++;
          if (b2b_arm) begin
            chk("b2b_start_cycle", 32'(cyc), 32'(b2b_exp));
            b2b_arm = 1'b0;
          end
          if (lat_req != lat_ack) begin
            chk("first_start_latency", 32'(cyc), 32'(lat_exp));
            lat_ack = lat_req;
          end
          if (exp_q.size() == 0) begin
            fail_now("unexpected_start");
            $display("FAIL unexpected_start actual=0x%0h expected=none", o_tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", 32'(o_tx_data), 32'(e));
          end
          pos = (pos + 1) % NB;
        end else if (i_tx_done && pos == 0 && exp_q.size() > 0) begin
          b2b_arm = 1'b1;
          b2b_exp = cyc + 1;
        end
      end
    end
  end

  task automatic post(input logic [31:0] d, input logic [23:0] inf, input bit wiggle,
                      input bit lat, output bit stalled);
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = d;
    i_info  = inf;
    stalled = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (o_ready) begin
        if (lat && !o_busy) begin
          lat_exp = cyc + 2;
          lat_req++;
        end
        push_pkt(i_data, i_info);
        @(negedge clk);
        i_valid = 1'b0;
        i_data  = $urandom;
        i_info  = 24'($urandom);
        return;
      end
      stalled = 1'b1;
      if (wiggle) begin
        i_data = $urandom;
        i_info = 24'($urandom);
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    fail_now("post_accept_timeout");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      if (!o_busy && exp_q.size() == 0) begin
        repeat (3) @(negedge clk);
        return;
      end
    end
    fail_now("idle_timeout");
  endtask

  initial begin
    bit st;
    int base;
    i_reset = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hCAFEF00D;
    i_info  = 24'h123456;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_start", 32'(o_tx_start), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_count", 32'(o_pkt_count), 32'd0);
    chk("reset_tx_data", 32'(o_tx_data), 32'd0);
    i_valid = 1'b0;
    i_reset = 1'b1;
    repeat (2) @(negedge clk);

    // single packet, slow UART
    dly_lo = 20; dly_hi = 20;
    post(32'h00001BD3, 24'h0A0B0C, 1'b0, 1'b1, st);
    wait_idle();
    chk("single_count", 32'(o_pkt_count), 32'(exp_pkts));

    // back-to-back with a third post stalling
    dly_lo = 4; dly_hi = 8;
    post(32'hA0A1A2A3, 24'hA4A5A6, 1'b0, 1'b0, st);
    repeat (3) @(negedge clk);
    chk("ready_during_A", 32'(o_ready), 32'd1);
    post(32'hB0B1B2B3, 24'hB4B5B6, 1'b0, 1'b0, st);
    chk("B_not_stalled", 32'(st), 32'd0);
    post(32'hC0C1C2C3, 24'hC4C5C6, 1'b0, 1'b0, st);
    chk("C_stalled", 32'(st), 32'd1);
    wait_idle();
    chk("b2b_count", 32'(o_pkt_count), 32'(exp_pkts));

    // spurious done in IDLE and in the START cycle
    spn_req++;
    repeat (3) @(negedge clk);
    chk("spur_idle_busy", 32'(o_busy), 32'd0);
    chk("spur_idle_count", 32'(o_pkt_count), 32'(exp_pkts));
    sos_req++;
    base = mon_starts;
    post(32'h5A5A0F0F, 24'h3C3CF0, 1'b0, 1'b0, st);
    wait_idle();
    chk("spur_start_nbytes", 32'(mon_starts - base), 32'(NB));
    chk("spur_count", 32'(o_pkt_count), 32'(exp_pkts));

    // reset mid-packet with a packet pending
    dly_lo = 3; dly_hi = 6;
    base = mon_starts;
    post(32'hDEADBEEF, 24'h123456, 1'b0, 1'b0, st);
    post(32'h87654321, 24'hFEDCBA, 1'b0, 1'b0, st);
    begin
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 500 && !hit; n++) begin
        @(negedge clk);
        #1;
        if (mon_starts >= base + 3 && i_tx_done) hit = 1'b1;
      end
      if (!hit) fail_now("byte2_done_timeout");
    end
    i_reset = 1'b0;
    exp_q.delete();
    exp_pkts = 0;
    flush_req++;
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    base = mon_starts;
    repeat (40) @(negedge clk);
    chk("starts_after_reset", 32'(mon_starts - base), 32'd0);
    chk("post_reset_count", 32'(o_pkt_count), 32'd0);
    chk("post_reset_busy", 32'(o_busy), 32'd0);
    chk("post_reset_ready", 32'(o_ready), 32'd1);
    post(32'h11223344, 24'h556677, 1'b0, 1'b0, st);
    wait_idle();
    chk("post_reset_pkt_count", 32'(o_pkt_count), 32'(exp_pkts));

    // randomized traffic with data wiggling while stalled
    for (int i = 0; i < 25; i++) begin
      dly_lo = 1;
      dly_hi = int'($urandom_range(6, 1));
      repeat ($urandom_range(8, 0)) @(negedge clk);
      post($urandom, 24'($urandom), 1'b1, 1'b0, st);
    end
    wait_idle();
    chk("random_count", 32'(o_pkt_count), 32'(exp_pkts));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
